// File: rtl/core_mem_arbiter.sv
// Two-master arbiter that merges the core's instruction-fetch and load/store buses
// onto one shared 16-bit memory bus. Ties go to data, or alternate, depending on data_priority.
module core_mem_arbiter #(
  parameter bit data_priority = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch master
  input  logic [18:0] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  // load/store master
  input  logic [18:0] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  // shared memory bus
  output logic [18:0] q_m_addr,
  output logic [15:0] q_m_data_out,
  input  logic [15:0] q_m_data_in,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] wdata;
    logic        wr_en;
    logic [1:0]  bytesel;
  } mem_req_t;

  state_t   state, state_nxt;
  logic     last_d, last_d_nxt;
  mem_req_t req_i, req_d, req_q;

  // Instruction fetches are always full-word reads.
  assign req_i = '{addr: instr_m_addr, wdata: 16'h0000, wr_en: 1'b0, bytesel: 2'b11};
  assign req_d = '{addr: data_m_addr, wdata: data_m_data_out, wr_en: data_m_wr_en,
                   bytesel: data_m_bytesel};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  // Outputs decode from the registered state only, so an async reset clears
  // access and acks in the same cycle it is asserted.
  always_comb begin
    state_nxt   = state;
    last_d_nxt  = last_d;
    req_q       = '0;
    q_m_access  = 1'b0;
    instr_m_ack = 1'b0;
    data_m_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (data_m_access && (!instr_m_access || data_priority || !last_d))
          state_nxt = SERVE_D;
        else if (instr_m_access)
          state_nxt = SERVE_I;
      end
      SERVE_I: begin
        req_q       = req_i;
        q_m_access  = instr_m_access;
        instr_m_ack = q_m_ack;
        if (q_m_ack) begin
          state_nxt  = IDLE;
          last_d_nxt = 1'b0;
        end
      end
      SERVE_D: begin
        req_q      = req_d;
        q_m_access = data_m_access;
        data_m_ack = q_m_ack;
        if (q_m_ack) begin
          state_nxt  = IDLE;
          last_d_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign q_m_addr     = req_q.addr;
  assign q_m_data_out = req_q.wdata;
  assign q_m_wr_en    = req_q.wr_en;
  assign q_m_bytesel  = req_q.bytesel;

  // Read data is broadcast; each master qualifies it with its own ack.
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: round-robin instance (index 0) and data-first instance
// (index 1) driven side by side, checked every cycle against an ownership model.
module tb_core_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [18:0] i_addr[2], d_addr[2], q_addr[2];
  logic        i_acc[2], i_ack[2], d_acc[2], d_wr[2], d_ack[2];
  logic        q_acc[2], q_ack[2], q_wr[2];
  logic [15:0] i_din[2], d_dout[2], d_din[2], q_dout[2], q_din[2];
  logic [1:0]  d_bs[2], q_bs[2];

  core_mem_arbiter #(.data_priority(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .instr_m_addr(i_addr[0]), .instr_m_access(i_acc[0]), .instr_m_ack(i_ack[0]),
    .instr_m_data_in(i_din[0]),
    .data_m_addr(d_addr[0]), .data_m_data_out(d_dout[0]), .data_m_access(d_acc[0]),
    .data_m_wr_en(d_wr[0]), .data_m_bytesel(d_bs[0]), .data_m_ack(d_ack[0]),
    .data_m_data_in(d_din[0]),
    .q_m_addr(q_addr[0]), .q_m_data_out(q_dout[0]), .q_m_data_in(q_din[0]),
    .q_m_access(q_acc[0]), .q_m_ack(q_ack[0]), .q_m_wr_en(q_wr[0]), .q_m_bytesel(q_bs[0])
  );

  core_mem_arbiter #(.data_priority(1'b1)) u_dp (
    .clk(clk), .reset(reset),
    .instr_m_addr(i_addr[1]), .instr_m_access(i_acc[1]), .instr_m_ack(i_ack[1]),
    .instr_m_data_in(i_din[1]),
    .data_m_addr(d_addr[1]), .data_m_data_out(d_dout[1]), .data_m_access(d_acc[1]),
    .data_m_wr_en(d_wr[1]), .data_m_bytesel(d_bs[1]), .data_m_ack(d_ack[1]),
    .data_m_data_in(d_din[1]),
    .q_m_addr(q_addr[1]), .q_m_data_out(q_dout[1]), .q_m_data_in(q_din[1]),
    .q_m_access(q_acc[1]), .q_m_ack(q_ack[1]), .q_m_wr_en(q_wr[1]), .q_m_bytesel(q_bs[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        acc;
    logic [18:0] addr;
    logic [15:0] dout;
    logic        wr;
    logic [1:0]  bs;
    logic        iack;
    logic        dack;
    logic [15:0] din_i;
    logic [15:0] din_d;
  } obs_t;

  // Model: who owns the bus (0 nobody, 1 instr, 2 data) and whether data was served last.
  int owner[2];
  bit served_d[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        owner[d]    = 0;
        served_d[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (owner[d] != 0) begin
          if (q_ack[d] === 1'b1) begin
            served_d[d] = (owner[d] == 2);
            owner[d]    = 0;
          end
        end else if (d_acc[d] && i_acc[d]) begin
          // index 1 is the data-first instance
          owner[d] = (d == 1 || !served_d[d]) ? 2 : 1;
        end else if (d_acc[d]) begin
          owner[d] = 2;
        end else if (i_acc[d]) begin
          owner[d] = 1;
        end
      end
    end
  end

  function automatic obs_t model_out(int d);
    obs_t o;
    o       = '0;
    o.din_i = q_din[d];
    o.din_d = q_din[d];
    if (owner[d] == 1) begin
      o.acc  = i_acc[d];
      o.addr = i_addr[d];
      o.bs   = 2'b11;
      o.iack = q_ack[d];
    end else if (owner[d] == 2) begin
      o.acc  = d_acc[d];
      o.addr = d_addr[d];
      o.dout = d_dout[d];
      o.wr   = d_wr[d];
      o.bs   = d_bs[d];
      o.dack = q_ack[d];
    end
    return o;
  endfunction

  function automatic obs_t dut_out(int d);
    obs_t o;
    o = '{acc: q_acc[d], addr: q_addr[d], dout: q_dout[d], wr: q_wr[d], bs: q_bs[d],
          iack: i_ack[d], dack: d_ack[d], din_i: i_din[d], din_d: d_din[d]};
    return o;
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      obs_t e, a;
      e = model_out(d);
      a = dut_out(d);
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL model dut%0d t=%0t got %h expected %h", d, $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic clear(input int d);
    i_addr[d] = '0; i_acc[d] = 1'b0;
    d_addr[d] = '0; d_dout[d] = '0; d_acc[d] = 1'b0; d_wr[d] = 1'b0; d_bs[d] = '0;
    q_ack[d]  = 1'b0; q_din[d] = '0;
  endtask

  // Both masters held on dut d; one-cycle acks; checks grant order and the idle gap.
  task automatic tie_run(input int d, input int n, input bit dfirst, input string nm);
    i_acc[d] = 1'b1; i_addr[d] = 19'h11111;
    d_acc[d] = 1'b1; d_addr[d] = 19'h22222; d_bs[d] = 2'b11;
    look();
    chk({nm, "_pre"}, {31'd0, q_acc[d]}, 32'd0);
    tick();
    for (int k = 0; k < n; k++) begin
      look();
      chk({nm, "_acc"}, {31'd0, q_acc[d]}, 32'd1);
      chk({nm, "_who"}, {13'd0, q_addr[d]},
          (dfirst || k % 2 == 0) ? 32'h22222 : 32'h11111);
      tick();
      q_ack[d] = 1'b1;
      look();
      tick();
      q_ack[d] = 1'b0;
      look();
      chk({nm, "_gap"}, {31'd0, q_acc[d]}, 32'd0);
      tick();
    end
    // abort: both masters drop while granted; grant holds until the memory ack
    i_acc[d] = 1'b0;
    d_acc[d] = 1'b0;
    look();
    chk({nm, "_abort_acc"}, {31'd0, q_acc[d]}, 32'd0);
    chk({nm, "_abort_addr"}, {13'd0, q_addr[d]}, 32'h22222);
    tick();
    q_ack[d] = 1'b1;
    look();
    chk({nm, "_abort_ack"}, {31'd0, d_ack[d]}, 32'd1);
    tick();
    clear(d);
  endtask

  initial begin
    bit i_seen[2], d_seen[2];
    reset = 1'b1;
    clear(0);
    clear(1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    look();
    chk("rst_acc", {31'd0, q_acc[1]}, 32'd0);
    chk("rst_addr", {13'd0, q_addr[1]}, 32'd0);
    chk("rst_bs", {30'd0, q_bs[1]}, 32'd0);
    tick();

    // reset mid-transfer
    d_acc[1] = 1'b1; d_addr[1] = 19'h1ABCD; d_bs[1] = 2'b10;
    look();
    chk("t1_idle", {31'd0, q_acc[1]}, 32'd0);
    tick();
    look();
    chk("t1_grant", {31'd0, q_acc[1]}, 32'd1);
    #1 q_ack[1] = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("t1_rst_acc", {31'd0, q_acc[1]}, 32'd0);
    chk("t1_rst_dack", {31'd0, d_ack[1]}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear(1);
    i_acc[1] = 1'b1; i_addr[1] = 19'h00010;
    look();
    chk("t1_post_idle", {31'd0, q_acc[1]}, 32'd0);
    tick();
    look();
    chk("t1_post_acc", {31'd0, q_acc[1]}, 32'd1);
    chk("t1_post_addr", {13'd0, q_addr[1]}, 32'h00010);
    tick();
    q_ack[1] = 1'b1;
    look();
    chk("t1_post_iack", {31'd0, i_ack[1]}, 32'd1);
    tick();
    clear(1);

    // instruction read
    i_acc[1] = 1'b1; i_addr[1] = 19'h12345;
    look();
    chk("t2_idle", {31'd0, q_acc[1]}, 32'd0);
    tick();
    look();
    chk("t2_acc", {31'd0, q_acc[1]}, 32'd1);
    chk("t2_addr", {13'd0, q_addr[1]}, 32'h12345);
    chk("t2_bs", {30'd0, q_bs[1]}, 32'd3);
    chk("t2_wr", {31'd0, q_wr[1]}, 32'd0);
    tick();
    tick();
    q_ack[1] = 1'b1; q_din[1] = 16'hBEEF;
    look();
    chk("t2_iack", {31'd0, i_ack[1]}, 32'd1);
    chk("t2_idata", {16'd0, i_din[1]}, 32'h0000BEEF);
    chk("t2_dack", {31'd0, d_ack[1]}, 32'd0);
    tick();
    clear(1);
    look();
    chk("t2_iack_pulse", {31'd0, i_ack[1]}, 32'd0);
    tick();

    // data write
    d_acc[1] = 1'b1; d_wr[1] = 1'b1; d_bs[1] = 2'b01;
    d_addr[1] = 19'h00400; d_dout[1] = 16'h00A5;
    tick();
    look();
    chk("t3_acc", {31'd0, q_acc[1]}, 32'd1);
    chk("t3_addr", {13'd0, q_addr[1]}, 32'h00400);
    chk("t3_dout", {16'd0, q_dout[1]}, 32'h000000A5);
    chk("t3_wr", {31'd0, q_wr[1]}, 32'd1);
    chk("t3_bs", {30'd0, q_bs[1]}, 32'd1);
    chk("t3_dack0", {31'd0, d_ack[1]}, 32'd0);
    tick();
    q_ack[1] = 1'b1;
    look();
    chk("t3_dack1", {31'd0, d_ack[1]}, 32'd1);
    chk("t3_iack", {31'd0, i_ack[1]}, 32'd0);
    tick();
    clear(1);
    look();
    chk("t3_done", {31'd0, q_acc[1]}, 32'd0);
    tick();

    // no mid-transfer switch; instr grant two cycles after the data ack
    d_acc[1] = 1'b1; d_addr[1] = 19'h0AAAA; d_bs[1] = 2'b11;
    tick();
    i_acc[1] = 1'b1; i_addr[1] = 19'h05555;
    look();
    chk("t6_hold0", {13'd0, q_addr[1]}, 32'h0AAAA);
    tick();
    look();
    chk("t6_hold1", {13'd0, q_addr[1]}, 32'h0AAAA);
    tick();
    q_ack[1] = 1'b1;
    look();
    chk("t6_dack", {31'd0, d_ack[1]}, 32'd1);
    chk("t6_iack0", {31'd0, i_ack[1]}, 32'd0);
    tick();
    q_ack[1] = 1'b0; d_acc[1] = 1'b0;
    look();
    chk("t6_turn", {31'd0, q_acc[1]}, 32'd0);
    tick();
    look();
    chk("t6_igrant", {31'd0, q_acc[1]}, 32'd1);
    chk("t6_iaddr", {13'd0, q_addr[1]}, 32'h05555);
    tick();
    q_ack[1] = 1'b1;
    look();
    tick();
    clear(1);
    q_ack[1] = 1'b1;
    look();
    chk("t6_spur_i", {31'd0, i_ack[1]}, 32'd0);
    chk("t6_spur_d", {31'd0, d_ack[1]}, 32'd0);
    tick();
    clear(1);
    tick();

    tie_run(1, 3, 1'b1, "t4");
    tie_run(0, 4, 1'b0, "t5");

    // randomized traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      look();
      for (int d = 0; d < 2; d++) begin
        i_seen[d] = i_ack[d];
        d_seen[d] = d_ack[d];
      end
      tick();
      reset = ($urandom_range(0, 599) == 0);
      for (int d = 0; d < 2; d++) begin
        if (i_acc[d] && (i_seen[d] || $urandom_range(0, 39) == 0)) begin
          i_acc[d] = 1'b0;
        end else if (!i_acc[d] && $urandom_range(0, 2) == 0) begin
          i_acc[d]  = 1'b1;
          i_addr[d] = 19'($urandom);
        end
        if (d_acc[d] && (d_seen[d] || $urandom_range(0, 39) == 0)) begin
          d_acc[d] = 1'b0;
        end else if (!d_acc[d] && $urandom_range(0, 2) == 0) begin
          d_acc[d]  = 1'b1;
          d_addr[d] = 19'($urandom);
          d_dout[d] = 16'($urandom);
          d_wr[d]   = 1'($urandom);
          d_bs[d]   = 2'($urandom);
        end
        q_ack[d] = ($urandom_range(0, 2) == 0);
        q_din[d] = 16'($urandom);
      end
    end
    look();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
